// File: rtl/hall_pkg.sv
// Shared sector encodings and sector-to-hall code table for the hall sensor emulator.
package hall_pkg;

    typedef enum logic [2:0] {
        SEC_0 = 3'd0,
        SEC_1 = 3'd1,
        SEC_2 = 3'd2,
        SEC_3 = 3'd3,
        SEC_4 = 3'd4,
        SEC_5 = 3'd5
    } sector_t;

    // {halla,hallb,hallc} per sector, sector 0 in the least significant slice.
    localparam logic [17:0] HALL_TABLE = {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
    localparam logic [2:0]  HALL_RESET = 3'b101;

    function automatic logic [2:0] hall_code(input sector_t s);
        logic [2:0] code;
        code = HALL_RESET;
        case (s)
            SEC_0:   code = HALL_TABLE[2:0];
            SEC_1:   code = HALL_TABLE[5:3];
            SEC_2:   code = HALL_TABLE[8:6];
            SEC_3:   code = HALL_TABLE[11:9];
            SEC_4:   code = HALL_TABLE[14:12];
            SEC_5:   code = HALL_TABLE[17:15];
            default: code = HALL_RESET;
        endcase
        return code;
    endfunction

    function automatic sector_t sector_step(input sector_t s, input logic rev);
        sector_t nxt;
        nxt = SEC_0;
        case (s)
            SEC_0:   nxt = rev ? SEC_5 : SEC_1;
            SEC_1:   nxt = rev ? SEC_0 : SEC_2;
            SEC_2:   nxt = rev ? SEC_1 : SEC_3;
            SEC_3:   nxt = rev ? SEC_2 : SEC_4;
            SEC_4:   nxt = rev ? SEC_3 : SEC_5;
            SEC_5:   nxt = rev ? SEC_4 : SEC_0;
            default: nxt = SEC_0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/hall_emu_timer.sv
// Step-period timer: shadow period, cycle counter and terminal-count strobe.
module hall_emu_timer
    import hall_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                load,
    output logic                tc
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_sh;
    logic [PERIOD_W-1:0] act_per;
    logic                en_d;

    // A fresh enable or a stopped (zero) shadow makes the live period take effect this cycle.
    assign load    = enable && (!en_d || (per_sh == '0));
    assign act_per = load ? period : per_sh;
    assign tc      = enable && (act_per != '0) && (cnt == (act_per - ONE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            per_sh <= '0;
            en_d   <= 1'b0;
        end else begin
            en_d <= enable;
            if (!enable || (act_per == '0) || tc)
                cnt <= '0;
            else
                cnt <= cnt + ONE;
            if (load || tc)
                per_sh <= period;
        end
    end

endmodule

// File: rtl/hall_emulator.sv
// Hall sensor emulator: six-sector commutation with free-run timer and single-step.
// Optional signed position counter enabled by defining HALL_EMU_POS_EN.
module hall_emulator
    import hall_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                dir,
    input  logic [PERIOD_W-1:0] period,
    input  logic                step_req,
    output logic                halla,
    output logic                hallb,
    output logic                hallc,
    output logic [2:0]          sector,
`ifdef HALL_EMU_POS_EN
    output logic [POS_W-1:0]    position,
`endif
    output logic                step_pulse
);

    logic    load;
    logic    tc;
    logic    dir_sh;
    logic    step;
    logic    step_rev;
    sector_t sector_q;
    sector_t sector_nxt;

    hall_emu_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .period (period),
        .load   (load),
        .tc     (tc)
    );

    // Free-run steps use the shadowed direction; single steps use the live input.
    always_comb begin
        step       = 1'b0;
        step_rev   = dir;
        sector_nxt = sector_q;
        if (enable) begin
            step     = tc;
            step_rev = load ? dir : dir_sh;
        end else begin
            step     = step_req;
            step_rev = dir;
        end
        if (step)
            sector_nxt = sector_step(sector_q, step_rev);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sector_q              <= SEC_0;
            {halla, hallb, hallc} <= HALL_RESET;
            step_pulse            <= 1'b0;
            dir_sh                <= 1'b0;
        end else begin
            sector_q              <= sector_nxt;
            {halla, hallb, hallc} <= hall_code(sector_nxt);
            step_pulse            <= step;
            if (load || tc)
                dir_sh <= dir;
        end
    end

    assign sector = sector_q;

`ifdef HALL_EMU_POS_EN
    localparam logic [POS_W-1:0] POS_INC = POS_W'(1);
    localparam logic [POS_W-1:0] POS_DEC = {POS_W{1'b1}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            position <= '0;
        else if (step)
            position <= position + (step_rev ? POS_DEC : POS_INC);
    end
`endif

endmodule

// File: tb/tb_hall_emulator.sv
// Scoreboard bench for hall_emulator: driver pushes reference-model expectations, monitor compares.
module tb_hall_emulator;

    localparam int PERIOD_W = 16;
    localparam int POS_W    = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                enable = 1'b0;
    logic                dir = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic                step_req = 1'b0;
    logic                halla, hallb, hallc;
    logic [2:0]          sector;
    logic                step_pulse;
`ifdef HALL_EMU_POS_EN
    logic [POS_W-1:0]    position;
`endif

    hall_emulator #(
        .PERIOD_W (PERIOD_W),
        .POS_W    (POS_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .period     (period),
        .step_req   (step_req),
        .halla      (halla),
        .hallb      (hallb),
        .hallc      (hallc),
        .sector     (sector),
`ifdef HALL_EMU_POS_EN
        .position   (position),
`endif
        .step_pulse (step_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int sec;
        int hall;
        bit pulse;
        int pos;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   drv_done = 1'b0;

    // Hall codes per sector, as 3-bit integers {a,b,c}.
    int hall_tab[6] = '{5, 4, 6, 2, 3, 1};

    // Reference model state, described in terms of the behavioural rules.
    int m_sec = 0, m_cnt = 0, m_per = 0, m_pos = 0;
    bit m_dir = 0, m_en_d = 0, m_pulse = 0;

    function automatic exp_t model_out();
        exp_t e;
        e.sec   = m_sec;
        e.hall  = hall_tab[m_sec];
        e.pulse = m_pulse;
        e.pos   = m_pos & ((1 << POS_W) - 1);
        return e;
    endfunction

    task automatic model_cycle(input bit r, input bit e, input bit d, input int p, input bit sr);
        bit step, rev, boundary;
        int ap;
        step = 0;
        rev  = d;
        if (!r) begin
            m_sec = 0; m_cnt = 0; m_per = 0; m_pos = 0;
            m_dir = 0; m_en_d = 0; m_pulse = 0;
            return;
        end
        if (e) begin
            boundary = !m_en_d || (m_per == 0);
            ap  = boundary ? p : m_per;
            rev = boundary ? d : m_dir;
            if (ap == 0) m_cnt = 0;
            else if (m_cnt == ap - 1) begin step = 1; m_cnt = 0; end
            else m_cnt++;
            if (boundary || step) begin m_per = p; m_dir = d; end
        end else begin
            m_cnt = 0;
            step  = sr;
        end
        m_en_d = e;
        if (step) begin
            m_sec = rev ? (m_sec + 5) % 6 : (m_sec + 1) % 6;
            m_pos = rev ? m_pos - 1 : m_pos + 1;
        end
        m_pulse = step;
    endtask

    task automatic cyc(input bit r, input bit e, input bit d, input int p, input bit sr);
        @(negedge clock);
        reset    = r;
        enable   = e;
        dir      = d;
        period   = PERIOD_W'(p);
        step_req = sr;
        model_cycle(r, e, d, p, sr);
        q.push_back(model_out());
    endtask

    task automatic direct_check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (sector != 3'(e.sec) || {halla, hallb, hallc} != 3'(e.hall) ||
                    step_pulse != e.pulse
`ifdef HALL_EMU_POS_EN
                    || position != POS_W'(e.pos)
`endif
                    ) begin
                    n_err++;
                    $display("FAIL cycle t=%0t: sector=%0d hall=%03b pulse=%0b expected sector=%0d hall=%03b pulse=%0b",
                             $time, sector, {halla, hallb, hallc}, step_pulse, e.sec, 3'(e.hall), e.pulse);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        // Reset state, then free run forward with period 4.
        repeat (3) cyc(0, 1, 0, 4, 0);
        direct_check("reset_hall", {halla, hallb, hallc}, 5);
        repeat (30) cyc(1, 1, 0, 4, 0);

        // Reverse run, period 2, from sector 0.
        repeat (2) cyc(0, 0, 1, 2, 0);
        repeat (10) cyc(1, 1, 1, 2, 0);

        // Period change 10 -> 3 mid-step.
        repeat (2) cyc(1, 0, 0, 10, 0);
        repeat (5) cyc(1, 1, 0, 10, 0);
        repeat (25) cyc(1, 1, 0, 3, 0);

        // Zero period stops, then period 1 steps every cycle.
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (50) cyc(1, 1, 0, 0, 0);
        repeat (10) cyc(1, 1, 0, 1, 0);

        // Single steps from sector 0.
        repeat (2) cyc(0, 0, 0, 5, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 5, 1);
            cyc(1, 0, 0, 5, 0);
        end
        @(posedge clock); #1;
        direct_check("single_step_sector", sector, 3);
`ifdef HALL_EMU_POS_EN
        direct_check("single_step_position", position, 3);
`endif

        // Mid-step reset: asserted at cycle 2 of a period-8 step.
        repeat (2) cyc(0, 0, 0, 8, 0);
        repeat (2) cyc(1, 1, 0, 8, 0);
        cyc(0, 1, 0, 8, 0);
        #1;
        direct_check("async_reset_hall", {halla, hallb, hallc}, 5);
        direct_check("async_reset_sector", sector, 0);
        direct_check("async_reset_pulse", step_pulse, 0);
        repeat (12) cyc(1, 1, 0, 8, 0);

        // Randomized mix of free run, single step, period/dir changes and resets.
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) > 2, 1'($urandom),
                $urandom_range(0, 5), 1'($urandom));
        end

        repeat (3) @(negedge clock);
        direct_check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
